led_fill_drain_checker: RTL

//  Monitor for the 8-bit fill/drain LED pattern driven on the board LED bus.

---
 rtl/led_chk_pkg.sv | 29 ++
 rtl/led_change_detect.sv | 35 +++
 rtl/led_fill_drain_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/led_chk_pkg.sv
// Shared state encoding, error codes and sequence successor function for the
// fill/drain LED pattern checker.
package led_chk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SEQ      = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_INTERVAL = 2'b11;

  // Successor of v in the fill/drain sequence on a bus of width w (w <= 64).
  function automatic logic [63:0] led_next(input logic [63:0] v, input int w);
    logic [63:0] mask;
    logic [63:0] vm;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    vm   = v & mask;
    if (vm == mask)
      led_next = mask & ~64'd1;
    else if (vm[0] || vm == 64'd0)
      led_next = ((vm << 1) | 64'd1) & mask;
    else
      led_next = (vm << 1) & mask;
  endfunction

endpackage

// File: rtl/led_change_detect.sv
// Two-stage LED bus sampler; change flags a difference between the two stages.
module led_change_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_in,
  output logic [WIDTH-1:0] led_q,
  output logic [WIDTH-1:0] led_p,
  output logic             change
);

  logic [WIDTH-1:0] led_d;
  logic [WIDTH-1:0] led_p_d;
  logic [WIDTH-1:0] led_p_q;

  always_comb begin
    led_d   = led_in;
    led_p_d = led_q;
  end

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      led_q   <= '0;
      led_p_q <= '0;
    end else begin
      led_q   <= led_d;
      led_p_q <= led_p_d;
    end
  end

  assign led_p  = led_p_q;
  assign change = (led_q != led_p_q);

endmodule

// File: rtl/led_fill_drain_checker.sv
// Fill/drain LED pattern checker: locks on 00->01, tracks each step, flags
// wrong steps and stalls. Define LED_CHK_INTERVAL_EN to also check step spacing.
module led_fill_drain_checker #(
  parameter int WIDTH          = 8,
  parameter int STEP_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int TOL            = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] period_count
);
  import led_chk_pkg::*;

  // Interval counter must reach both the timeout and the top of the step window.
  localparam int IV_MAX = (TIMEOUT_CYCLES > STEP_CYCLES + TOL) ? TIMEOUT_CYCLES : STEP_CYCLES + TOL;
  localparam int IV_W   = $clog2(IV_MAX + 1);
  localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);

  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] led_p;
  logic             change;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [IV_W-1:0]  ivl_q, ivl_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] period_count_q, period_count_d;
`ifdef LED_CHK_INTERVAL_EN
  logic             first_q, first_d;
`endif

  logic             err_hit;
  logic [1:0]       err_kind;
  logic [63:0]      next_full;
  logic [WIDTH-1:0] next_val;
  logic             unused_next_hi;

  led_change_detect #(.WIDTH(WIDTH)) u_change (
    .clk_50M (clk_50M),
    .reset   (reset),
    .led_in  (led_in),
    .led_q   (led_q),
    .led_p   (led_p),
    .change  (change)
  );

  assign next_full      = led_next(64'(led_q), WIDTH);
  assign next_val       = next_full[WIDTH-1:0];
  assign unused_next_hi = |next_full[63:WIDTH];

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_q        <= IDLE;
      expected_q     <= '0;
      ivl_q          <= '0;
      err_pulse_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
      err_count_q    <= '0;
      period_count_q <= '0;
`ifdef LED_CHK_INTERVAL_EN
      first_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      ivl_q          <= ivl_d;
      err_pulse_q    <= err_pulse_d;
      err_code_q     <= err_code_d;
      err_count_q    <= err_count_d;
      period_count_q <= period_count_d;
`ifdef LED_CHK_INTERVAL_EN
      first_q        <= first_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    ivl_d          = ivl_q;
    err_pulse_d    = 1'b0;
    err_code_d     = err_code_q;
    err_count_d    = err_count_q;
    period_count_d = period_count_q;
    err_hit        = 1'b0;
    err_kind       = ERR_NONE;
`ifdef LED_CHK_INTERVAL_EN
    first_d        = first_q;
`endif
    case (state_q)
      IDLE: begin
        ivl_d = '0;
        if (change && led_p == '0 && led_q == LED_ONE) begin
          state_d    = TRACK;
          expected_d = next_val;
`ifdef LED_CHK_INTERVAL_EN
          first_d    = 1'b1;
`endif
        end
      end
      TRACK: begin
        // A change in the same cycle as the timeout wins over the timeout.
        if (change) begin
          ivl_d = '0;
          if (led_q == expected_q) begin
            expected_d = next_val;
            if (led_q == '0 && period_count_q != '1)
              period_count_d = period_count_q + 1'b1;
`ifdef LED_CHK_INTERVAL_EN
            first_d = 1'b0;
            if (!first_q && ((int'(ivl_q) + 1 < STEP_CYCLES - TOL) ||
                             (int'(ivl_q) + 1 > STEP_CYCLES + TOL))) begin
              err_hit  = 1'b1;
              err_kind = ERR_INTERVAL;
            end
`endif
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_SEQ;
            state_d  = IDLE;
          end
        end else if (ivl_q == IV_W'(TIMEOUT_CYCLES - 1)) begin
          err_hit  = 1'b1;
          err_kind = ERR_TIMEOUT;
          state_d  = IDLE;
          ivl_d    = '0;
        end else begin
          ivl_d = ivl_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = err_kind;
      if (err_count_q != '1)
        err_count_d = err_count_q + 1'b1;
    end
  end

  always_comb begin
    locked       = (state_q == TRACK);
    err_pulse    = err_pulse_q;
    err_code     = err_code_q;
    err_count    = err_count_q;
    period_count = period_count_q;
  end

endmodule
